// File: rtl/vga_update_sched.sv
// Frame-synchronous VGA update scheduler: CPU/Eth round-robin into a FIFO, one word committed per frame tick (disp_we 4 edges after frame_start).
// Grants withheld while full; `define VGA_SCHED_SKIP_EN commits the newest word and flushes older ones.
module vga_update_sched #(
   parameter int DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_data,
   output logic        cpu_gnt,
   input  logic        eth_req,
   input  logic [31:0] eth_data,
   output logic        eth_gnt,
   input  logic        frame_start,
   input  logic        irq_clr,
   output logic        disp_we,
   output logic [31:0] disp_data,
   output logic        irq,
   output logic [31:0] status
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = 4;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, COMMIT, WAIT_LOW} state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, tick_q, tick_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic          last_eth_q, last_eth_d;
   logic          irq_q, irq_d;
   logic          disp_we_q, disp_we_d;
   logic [31:0]   disp_data_q, disp_data_d;
   logic [7:0]    commit_cnt_q, commit_cnt_d;
   logic [7:0]    drop_cnt;
   logic          room, push, pop, flush;
   logic [31:0]   push_data;

`ifdef VGA_SCHED_SKIP_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;
   logic [8:0] drop_sum;
   assign drop_sum = {1'b0, drop_cnt_q} + 9'(count_q) - 9'd1;
   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'd0;
`endif

   // Grants depend only on req, occupancy and the pointer; a same-cycle pop frees no slot.
   assign room      = (count_q < DEPTH_C) && !rst;
   assign cpu_gnt   = room && cpu_req && (!eth_req || last_eth_q);
   assign eth_gnt   = room && eth_req && (!cpu_req || !last_eth_q);
   assign push      = cpu_gnt || eth_gnt;
   assign push_data = cpu_gnt ? cpu_data : eth_data;

   always_comb begin
      sync1_d    = frame_start;
      sync2_d    = sync1_q;
      sync3_d    = sync2_q;
      tick_d     = sync2_q && !sync3_q;
      last_eth_d = last_eth_q;
      if (cpu_gnt) begin
         last_eth_d = 1'b0;
      end else if (eth_gnt) begin
         last_eth_d = 1'b1;
      end
   end

   // The commit work is done on the edge entering COMMIT, so disp_we is high for the COMMIT cycle.
   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      flush        = 1'b0;
      disp_we_d    = 1'b0;
      disp_data_d  = disp_data_q;
      commit_cnt_d = commit_cnt_q;
`ifdef VGA_SCHED_SKIP_EN
      drop_cnt_d   = drop_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (tick_q && count_q != '0) begin
               state_d      = COMMIT;
               disp_we_d    = 1'b1;
               pop          = 1'b1;
               commit_cnt_d = commit_cnt_q + 8'd1;
               disp_data_d  = mem_q[rd_ptr_q];
`ifdef VGA_SCHED_SKIP_EN
               if (count_q > CW'(1)) begin
                  flush       = 1'b1;
                  disp_data_d = mem_q[wr_ptr_q - PW'(1)];
                  drop_cnt_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
               end
`endif
            end
         end
         COMMIT:   state_d = WAIT_LOW;
         WAIT_LOW: if (!sync2_q) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         count_d  = count_q - CW'(1);
      end
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         count_d         = count_d + CW'(1);
      end
      irq_d = irq_q;
      if (push || irq_clr) irq_d = 1'b0;
      if (pop && count_d == '0) irq_d = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         tick_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_eth_q   <= 1'b1;
         irq_q        <= 1'b0;
         disp_we_q    <= 1'b0;
         disp_data_q  <= 32'hFFFF_FFFF;
         commit_cnt_q <= 8'd0;
`ifdef VGA_SCHED_SKIP_EN
         drop_cnt_q   <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
         tick_q       <= tick_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_eth_q   <= last_eth_d;
         irq_q        <= irq_d;
         disp_we_q    <= disp_we_d;
         disp_data_q  <= disp_data_d;
         commit_cnt_q <= commit_cnt_d;
`ifdef VGA_SCHED_SKIP_EN
         drop_cnt_q   <= drop_cnt_d;
`endif
      end
   end

   always_ff @(posedge clk_in) begin
      mem_q <= mem_d;
   end

   assign disp_we   = disp_we_q;
   assign disp_data = disp_data_q;
   assign irq       = irq_q;
   assign status    = {8'd0, drop_cnt, commit_cnt_q, 1'b0, irq_q,
                       (count_q == '0), (count_q == DEPTH_C), count_q};

endmodule

// File: tb/tb_vga_update_sched.sv
// Bench for vga_update_sched: table-driven arbitration plus frame/commit sequences, scoreboard of granted words.
module tb_vga_update_sched;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, eth_req = 1'b0;
   logic [31:0] cpu_data = '0, eth_data = '0;
   logic        cpu_gnt, eth_gnt;
   logic        frame_start = 1'b0, irq_clr = 1'b0;
   logic        disp_we, irq;
   logic [31:0] disp_data, status;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int we_count = 0;
   int we_cyc = 0;
   logic [31:0] q[$];

   typedef struct {
      logic        cr, er;
      logic [31:0] cd, ed;
      logic        xc, xe;
      logic [3:0]  xcount;
      logic        xfull;
   } vec_t;
   vec_t tbl[6];

   vga_update_sched #(.DEPTH(4)) dut (
      .clk_in(clk_in), .rst(rst),
      .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
      .eth_req(eth_req), .eth_data(eth_data), .eth_gnt(eth_gnt),
      .frame_start(frame_start), .irq_clr(irq_clr),
      .disp_we(disp_we), .disp_data(disp_data), .irq(irq), .status(status)
   );

   always #10 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Grants are sampled late in the cycle, just before the accepting edge.
   always begin
      @(negedge clk_in);
      #3;
      if (cpu_gnt) q.push_back(cpu_data);
      if (eth_gnt) q.push_back(eth_data);
   end

   always begin
      logic [31:0] exp;
      @(posedge clk_in);
      #1;
      if (disp_we) begin
         we_count++;
         we_cyc = cyc;
         if (q.size() == 0) begin
            chk("commit_without_word", 32'(q.size()), 32'd1);
         end else begin
`ifdef VGA_SCHED_SKIP_EN
            exp = q[$];
            q.delete();
`else
            exp = q.pop_front();
`endif
            chk("commit_data", disp_data, exp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_in);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      q.delete();
      #5;
      chk("gnt_in_reset", {30'd0, cpu_gnt, eth_gnt}, 32'd0);
      @(posedge clk_in);
      @(posedge clk_in);
      #2;
      rst = 1'b0;
   endtask

   task automatic push_word(input bit is_eth, input logic [31:0] d);
      bit g;
      if (is_eth) begin eth_req = 1'b1; eth_data = d; end
      else begin cpu_req = 1'b1; cpu_data = d; end
      for (int i = 0; i < 40; i++) begin
         #5;
         g = is_eth ? eth_gnt : cpu_gnt;
         step();
         if (g) begin
            if (is_eth) eth_req = 1'b0; else cpu_req = 1'b0;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL push_timeout: word %h never granted", d);
      cpu_req = 1'b0;
      eth_req = 1'b0;
   endtask

   task automatic frame_pulse(input int w);
      frame_start = 1'b1;
      repeat (w) step();
      frame_start = 1'b0;
   endtask

   task automatic wait_commit(input int base);
      for (int i = 0; i < 20; i++) begin
         if (we_count > base) return;
         step();
      end
      total++;
      bad++;
      $display("FAIL commit_timeout: got %0d strobes expected more than %0d", we_count, base);
   endtask

   initial begin
      int c, base;
      logic g[5];

      tbl[0] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 4'd0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 32'hC000_0000, 32'hE000_0000, 1'b1, 1'b0, 4'd1, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 32'hC000_0001, 32'hE000_0001, 1'b0, 1'b1, 4'd2, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 32'hC000_0002, 32'hE000_0002, 1'b1, 1'b0, 4'd3, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 32'hC000_0003, 32'hE000_0003, 1'b0, 1'b1, 4'd4, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 32'hC000_0004, 32'hE000_0004, 1'b0, 1'b0, 4'd4, 1'b1};

      // Reset state and idle frames
      reset_dut();
      chk("reset_status", status, 32'h0000_0020);
      chk("reset_disp_data", disp_data, 32'hFFFF_FFFF);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         frame_pulse(3);
         idle(6);
      end
      chk("idle_no_strobe", we_count, 0);

      // Single word, commit latency, irq set and clear
      push_word(1'b0, 32'h1234_5678);
      base = we_count;
      c = cyc;
      frame_pulse(3);
      wait_commit(base);
      chk("commit_latency", we_cyc - c, 4);
      chk("disp_data_single", disp_data, 32'h1234_5678);
      chk("irq_after_drain", {31'd0, irq}, 32'd1);
      chk("commit_cnt_1", status & 32'h0000_FF00, 32'h0000_0100);
      step();
      chk("we_single_cycle", {31'd0, disp_we}, 32'd0);
      chk("data_held", disp_data, 32'h1234_5678);
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      idle(4);

      // Round-robin arbitration table
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         cpu_req = tbl[i].cr; eth_req = tbl[i].er;
         cpu_data = tbl[i].cd; eth_data = tbl[i].ed;
         #5;
         chk($sformatf("gnt_row%0d", i), {30'd0, cpu_gnt, eth_gnt}, {30'd0, tbl[i].xc, tbl[i].xe});
         step();
         chk($sformatf("count_row%0d", i), status & 32'h1F, {27'd0, tbl[i].xfull, tbl[i].xcount});
      end
      cpu_req = 1'b0;
      eth_req = 1'b0;

      // Full FIFO: request coincides with the tick, grant follows the pop
      cpu_req = 1'b1;
      cpu_data = 32'hC000_0005;
      c = cyc;
      frame_start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #5;
         g[k] = cpu_gnt;
         step();
      end
      cpu_req = 1'b0;
      frame_start = 1'b0;
      chk("full_no_grant", {28'd0, g[0], g[1], g[2], g[3]}, 32'd0);
      chk("grant_after_pop", {31'd0, g[4]}, 32'd1);
      chk("full_commit_cycle", we_cyc - c, 4);
`ifdef VGA_SCHED_SKIP_EN
      chk("count_after_refill", status & 32'hF, 32'd1);
`else
      chk("count_after_refill", status & 32'hF, 32'd4);
`endif
      idle(4);

      // Reset with a held request discards contents, then re-arbitrates
      cpu_req = 1'b1;
      cpu_data = 32'hAAAA_0001;
      reset_dut();
      chk("reset_discards", status & 32'h3F, 32'h20);
      push_word(1'b0, 32'hAAAA_0001);
      push_word(1'b0, 32'hBBBB_0002);
      push_word(1'b1, 32'hCCCC_0003);
      push_word(1'b0, 32'hDDDD_0004);
      chk("filled", status & 32'h1F, 32'h14);
`ifdef VGA_SCHED_SKIP_EN
      irq_clr = 1'b1;
      base = we_count;
      frame_pulse(3);
      wait_commit(base);
      chk("irq_set_wins", {31'd0, irq}, 32'd1);
      irq_clr = 1'b0;
      chk("skip_newest", disp_data, 32'hDDDD_0004);
      chk("skip_flushed", status & 32'h3F, 32'h20);
      chk("skip_drop_cnt", status & 32'h00FF_0000, 32'h0003_0000);
      chk("skip_commit_cnt", status & 32'h0000_FF00, 32'h0000_0100);
      idle(3);
`else
      for (int f = 0; f < 4; f++) begin
         if (f == 3) irq_clr = 1'b1;
         base = we_count;
         frame_pulse(3);
         wait_commit(base);
         if (f < 3) idle(3);
      end
      chk("irq_set_wins", {31'd0, irq}, 32'd1);
      irq_clr = 1'b0;
      chk("drained_empty", status & 32'h3F, 32'h20);
      chk("commit_cnt_4", status & 32'h00FF_FF00, 32'h0000_0400);
      chk("last_word", disp_data, 32'hDDDD_0004);
      idle(3);
`endif

      // Long frame_start high: one commit per rising edge
      push_word(1'b1, 32'h5555_0001);
      chk("push_clears_irq", {31'd0, irq}, 32'd0);
      push_word(1'b0, 32'h6666_0002);
      base = we_count;
      frame_start = 1'b1;
      idle(1000);
      chk("one_commit_long_frame", we_count - base, 1);
      frame_start = 1'b0;
      idle(4);
`ifdef VGA_SCHED_SKIP_EN
      chk("skip_long_empty", status & 32'hF, 32'd0);
      chk("skip_drop_cnt_4", status & 32'h00FF_0000, 32'h0004_0000);
`else
      chk("second_waiting", status & 32'hF, 32'd1);
      frame_pulse(3);
      wait_commit(base + 1);
      chk("second_commit", we_count - base, 2);
      chk("second_word", disp_data, 32'h6666_0002);
`endif
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_update_sched.md
# vga_update_sched

Frame-synchronous update scheduler for the VGA display register. It arbitrates display-word writes from two requesters, the CPU and the Ethernet receive path, into a small FIFO. It then commits exactly one word per video frame to the VGA block's write port (we/i_data), so the displayed value never changes mid-frame. It sits in the 50 MHz clk_in domain, between the bus/Ethernet logic and the VGA block, and takes the VGA block's frame-restart flag as its frame tick.

## Interface
- DEPTH, 4, FIFO depth in words; power of two, 2..8
- clk_in  in  1  50 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU requests a push; holds req and cpu_data until granted
- cpu_data  in  32  CPU display word
- cpu_gnt  out  1  combinational; word accepted at this rising edge
- eth_req  in  1  Ethernet path requests a push; same rules as CPU
- eth_data  in  32  Ethernet display word
- eth_gnt  out  1  combinational grant for eth
- frame_start  in  1  VGA restart level, 25 MHz domain, asynchronous to clk_in
- irq_clr  in  1  clears irq
- disp_we  out  1  one-cycle write strobe to VGA we
- disp_data  out  32  word to VGA i_data, held between commits
- irq  out  1  level; FIFO drained by a commit
- status  out  32  [3:0] count, [4] full, [5] empty, [6] irq, [15:8] commit_cnt, [23:16] drop_cnt, rest 0

## Operation
- Arbiter: grants at most one requester per cycle, and only when count < DEPTH at the start of the cycle. A concurrent pop gives no credit.
- Round-robin: with both requesting, grant the one not granted last. The last-grant pointer resets to eth, so the CPU wins the first tie.
- Push: the granted data is written at the tail and count increments.
- frame_start passes through a 2-flop synchronizer. A rising edge of the synchronized level is the frame tick.
- Commit FSM:
  - IDLE: on tick with count>0, go to COMMIT. On tick with count==0, stay in IDLE with no strobe.
  - COMMIT: 1 cycle. Register the head word into disp_data, assert disp_we, pop, increment commit_cnt (mod 256), go to WAIT_LOW.
  - WAIT_LOW: stay until the synchronized frame_start is 0, then go to IDLE.
- Push and pop in the same cycle: both occur and count is unchanged.
- irq: set when a pop leaves count==0. Cleared by irq_clr or by any push. If set and clear coincide, set wins.
- Reset values: disp_we=0, disp_data=32'hFFFF_FFFF (matches the VGA register's reset), irq=0, FIFO empty, count=0, both counters 0, FSM=IDLE, sync flops 0. status therefore reads 32'h0000_0020.
- A reset mid-operation discards FIFO contents. A req held across reset is re-arbitrated after reset deasserts.

## Timing
- frame_start rises before clk_in edge E0. It is seen at sync1 at E0 and sync2 at E1.
- The tick is registered at E2. disp_we is high for exactly the cycle after E3, and disp_data is valid from that same edge.
- At most one commit per frame_start high period, whatever its width.
- Grant to head-of-FIFO latency: a word pushed into an empty FIFO is eligible on the next tick.
- Grants are combinational from req, count and the pointer. There is no combinational path from data to grant.

## Configuration
- VGA_SCHED_SKIP_EN defined:
  - In COMMIT with count>1, commit the newest (tail) word and flush the FIFO.
  - drop_cnt increments by count-1, saturating at 255.
  - The latest-value-wins policy is for live Ethernet data.
- Undefined: strict FIFO order, one word per frame, and drop_cnt is constant 0.

## Test plan
- Reset, then no activity: status=32'h0000_0020, disp_data=32'hFFFF_FFFF, disp_we never asserts across 3 frame_start pulses.
- CPU pushes 32'h12345678, then one frame_start pulse: disp_we is a single cycle 4 edges after the pulse (per Timing) with disp_data=32'h12345678; irq=1, commit_cnt=1; irq_clr then gives irq=0.
- cpu_req and eth_req held together for 4 cycles with DEPTH=4: grants go cpu, eth, cpu, eth, then no grants (full=1, count=4).
- Fill with A,B,C,D, then 4 frames: without the macro the commits are A,B,C,D in order and empty=1 after the 4th. With VGA_SCHED_SKIP_EN a single frame commits D, count=0, drop_cnt=3.
- frame_start held high for 1000 clk_in cycles with 2 words queued: exactly one commit, and the second word commits on the next rising edge.
- Full FIFO, push request and tick in the same cycle: no grant that cycle, pop occurs, and the grant follows on the next cycle (count returns to 4).
